// File: rtl/nibble_parity_tx_pkg.sv
// Shared types and constants for the nibble serial transmitter.
package nibble_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // start + 4 data + parity + stop
  localparam int FRAME_BITS = 7;

  // Level of the serial line when nothing is being sent.
  localparam logic TX_IDLE = 1'b1;

  // Index of the last data bit (d3) in the 2-bit data bit counter.
  localparam logic [1:0] LAST_DATA_BIT = 2'd3;

endpackage

// File: rtl/nibble_parity_tx_if.sv
// Valid/ready nibble handshake between upstream producer and the transmitter.
interface nibble_parity_tx_if;

  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/nibble_parity_tx_xor4.sv
// Existing 4-input parity stage: y is the XOR of all four input bits.
module xor4 (
  input  logic [3:0] a,
  output logic       y
);

  assign y = ^a;

endmodule

// File: rtl/nibble_parity_tx.sv
// Nibble serial transmitter: frames a 4-bit nibble as start, d0..d3, even
// parity and stop, each bit held for BIT_CYCLES clocks, LSB first.
module nibble_parity_tx
  import nibble_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  nibble_parity_tx_if.slave        up,
  output logic                     tx,
  output logic                     busy,
  output logic                     frame_done
);

  localparam logic [7:0] LAST_CYCLE = 8'(BIT_CYCLES - 1);

  tx_state_t  state_r;
  logic [7:0] cyc_r;
  logic [1:0] bit_r;
  logic [3:0] shreg_r;
  logic       par_r;
  logic       tx_r;
  logic       busy_r;
  logic       done_r;

  logic       par_s;
  logic       accept_s;
  logic       bit_end_s;

  // Parity is computed combinationally from the offered nibble and only
  // captured on accept, so later changes on in_data cannot reach the frame.
  xor4 u_xor4 (
    .a (up.in_data),
    .y (par_s)
  );

  assign up.in_ready = (state_r == IDLE);
  assign accept_s    = up.in_valid && (state_r == IDLE);
  assign bit_end_s   = (cyc_r == LAST_CYCLE);

  assign tx         = tx_r;
  assign busy       = busy_r;
  assign frame_done = done_r;

  // Frame sequencer: state, bit timing, shift register and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cyc_r   <= 8'd0;
      bit_r   <= 2'd0;
      shreg_r <= 4'd0;
      par_r   <= 1'b0;
      tx_r    <= TX_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // frame_done is only ever high for the first IDLE cycle
          done_r <= 1'b0;
          cyc_r  <= 8'd0;
          bit_r  <= 2'd0;
          if (accept_s) begin
            shreg_r <= up.in_data;
            par_r   <= par_s;
            state_r <= START;
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            tx_r   <= TX_IDLE;
            busy_r <= 1'b0;
          end
        end

        START: begin
          if (bit_end_s) begin
            cyc_r   <= 8'd0;
            state_r <= DATA;
            tx_r    <= shreg_r[0];
          end else begin
            cyc_r <= cyc_r + 8'd1;
          end
        end

        DATA: begin
          if (bit_end_s) begin
            cyc_r <= 8'd0;
            if (bit_r == LAST_DATA_BIT) begin
              state_r <= PARITY;
              tx_r    <= par_r;
            end else begin
              // the next bit to drive is the one about to reach bit 0
              shreg_r <= shreg_r >> 1;
              tx_r    <= shreg_r[1];
              bit_r   <= bit_r + 2'd1;
            end
          end else begin
            cyc_r <= cyc_r + 8'd1;
          end
        end

        PARITY: begin
          if (bit_end_s) begin
            cyc_r   <= 8'd0;
            state_r <= STOP;
            tx_r    <= TX_IDLE;
          end else begin
            cyc_r <= cyc_r + 8'd1;
          end
        end

        STOP: begin
          if (bit_end_s) begin
            cyc_r   <= 8'd0;
            state_r <= IDLE;
            tx_r    <= TX_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            cyc_r <= cyc_r + 8'd1;
          end
        end

        default: begin
          // unreachable encoding: fall back to a quiet idle line
          state_r <= IDLE;
          cyc_r   <= 8'd0;
          bit_r   <= 2'd0;
          tx_r    <= TX_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_parity_tx.sv
// Directed bench for nibble_parity_tx: one instance with BIT_CYCLES=4 and one
// with BIT_CYCLES=1 share clock and reset; every output is checked per cycle.
module tb_nibble_parity_tx;
  import nibble_tx_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  nibble_parity_tx_if if4 ();
  nibble_parity_tx_if if1 ();

  logic tx4, busy4, fd4;
  logic tx1, busy1, fd1;

  nibble_parity_tx #(.BIT_CYCLES(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .up         (if4.slave),
    .tx         (tx4),
    .busy       (busy4),
    .frame_done (fd4)
  );

  nibble_parity_tx #(.BIT_CYCLES(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .up         (if1.slave),
    .tx         (tx1),
    .busy       (busy1),
    .frame_done (fd1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // hand-derived parity of nibbles 0..15, bit i = parity of i
  logic [15:0] par_tab;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int bc);
    chk($sformatf("%s_tx", tag),    (bc == 1) ? tx1 : tx4, 1'b1);
    chk($sformatf("%s_ready", tag), (bc == 1) ? if1.in_ready : if4.in_ready, 1'b1);
    chk($sformatf("%s_busy", tag),  (bc == 1) ? busy1 : busy4, 1'b0);
    chk($sformatf("%s_done", tag),  (bc == 1) ? fd1 : fd4, 1'b0);
  endtask

  // Offer a nibble at a falling edge; returns 1 time unit after the accept edge.
  task automatic start_frame(input int bc, input logic [3:0] d, input bit hold);
    @(negedge clk);
    if (bc == 1) begin
      if1.in_valid = 1'b1;
      if1.in_data  = d;
    end else begin
      if4.in_valid = 1'b1;
      if4.in_data  = d;
    end
    chk("accept_ready", (bc == 1) ? if1.in_ready : if4.in_ready, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) begin
      if1.in_valid = 1'b0;
      if4.in_valid = 1'b0;
    end
  endtask

  // Check every cycle of a frame whose accept edge has just passed,
  // then the frame_done cycle.
  task automatic check_frame(input int bc, input logic [3:0] d, input logic p,
                             input string tag);
    logic [6:0] f;
    f = {TX_IDLE, p, d, 1'b0};
    for (int j = 0; j < FRAME_BITS * bc; j++) begin
      @(negedge clk);
      chk($sformatf("%s_tx_c%0d", tag, j + 1),   (bc == 1) ? tx1 : tx4, f[j / bc]);
      chk($sformatf("%s_busy_c%0d", tag, j + 1), (bc == 1) ? busy1 : busy4, 1'b1);
      chk($sformatf("%s_done_c%0d", tag, j + 1), (bc == 1) ? fd1 : fd4, 1'b0);
    end
    @(negedge clk);
    chk($sformatf("%s_done_pulse", tag), (bc == 1) ? fd1 : fd4, 1'b1);
    chk($sformatf("%s_done_tx", tag),    (bc == 1) ? tx1 : tx4, 1'b1);
    chk($sformatf("%s_done_busy", tag),  (bc == 1) ? busy1 : busy4, 1'b0);
    chk($sformatf("%s_done_ready", tag), (bc == 1) ? if1.in_ready : if4.in_ready, 1'b1);
  endtask

  initial begin
    par_tab      = 16'h6996;
    if4.in_valid = 1'b0;
    if4.in_data  = 4'h0;
    if1.in_valid = 1'b0;
    if1.in_data  = 4'h0;
    rst_n        = 1'b0;

    // reset held for 3 cycles, then 5 idle cycles
    repeat (3) @(negedge clk);
    chk_idle("rst4", 4);
    chk_idle("rst1", 1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle($sformatf("idle4_%0d", i), 4);
      chk_idle($sformatf("idle1_%0d", i), 1);
    end

    // all-zero nibble: parity 0
    start_frame(4, 4'b0000, 1'b0);
    check_frame(4, 4'b0000, 1'b0, "f0000");

    // 1011 with in_data changed after accept: parity 1
    start_frame(4, 4'b1011, 1'b0);
    if4.in_data = 4'hF;
    check_frame(4, 4'b1011, 1'b1, "f1011");

    // back-to-back with in_valid held throughout the first frame
    start_frame(4, 4'b0001, 1'b1);
    if4.in_data = 4'b1111;
    check_frame(4, 4'b0001, 1'b1, "b2b_a");
    @(posedge clk);
    #1;
    if4.in_valid = 1'b0;
    check_frame(4, 4'b1111, 1'b0, "b2b_b");

    // reset 10 cycles into a frame
    start_frame(4, 4'b0110, 1'b0);
    repeat (10) @(negedge clk);
    chk("midrst_busy_before", busy4, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx",    tx4, 1'b1);
    chk("midrst_busy",  busy4, 1'b0);
    chk("midrst_done",  fd4, 1'b0);
    chk("midrst_ready", if4.in_ready, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_hold_done%0d", i), fd4, 1'b0);
      chk($sformatf("midrst_hold_tx%0d", i),   tx4, 1'b1);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle($sformatf("postrst_%0d", i), 4);
    end
    start_frame(4, 4'b0111, 1'b0);
    check_frame(4, 4'b0111, 1'b1, "f0111");

    // every nibble with one clock per bit
    for (int i = 0; i < 16; i++) begin
      logic [3:0] d;
      d = 4'(i);
      start_frame(1, d, 1'b0);
      check_frame(1, d, par_tab[i], $sformatf("bc1_n%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
